// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default sizes and FSM encoding.
package rf_write_arbiter_pkg;

    localparam int unsigned DefDataW   = 8;
    localparam int unsigned DefAddrW   = 3;
    localparam int unsigned DefNumRegs = 8;

    typedef enum logic {
        StRun   = 1'b0,
        StClear = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The priority flop points at the requester that wins a tie;
// it flips to the other requester after every grant and holds on idle cycles.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    output logic [1:0] ready_o,
    output logic [1:0] grant_o,
    output logic       prio_o
);

    logic prio_q, prio_d;

    // Ready does not depend on the requester's own valid, only on the competitor's.
    always_comb begin
        ready_o[0] = enable_i & (~prio_q | ~valid_i[1]);
        ready_o[1] = enable_i & (prio_q | ~valid_i[0]);
        grant_o    = ready_o & valid_i;
        prio_d     = prio_q;
        if (grant_o[0]) begin
            prio_d = 1'b1;
        end else if (grant_o[1]) begin
            prio_d = 1'b0;
        end
    end

    // Priority register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign prio_o = prio_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner: arbitrates two requesters round-robin and runs a
// sequencer that zeroes every register on command. All register-file outputs are registered.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned NUM_REGS = DefNumRegs
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_start_i,
    output logic              clr_busy_o,
    input  logic              r0_valid_i,
    output logic              r0_ready_o,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_data_i,
    input  logic              r1_valid_i,
    output logic              r1_ready_o,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_data_i,
    output logic              rf_load_o,
    output logic [ADDR_W-1:0] rf_address_o,
    output logic [DATA_W-1:0] rf_d_in_o,
    output logic              last_grant_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              lg_q, lg_d;

    logic       arb_enable;
    logic [1:0] arb_ready;
    logic [1:0] arb_grant;
    logic       arb_prio;

    // A clear request takes the cycle, so nobody may be handed the port alongside it.
    assign arb_enable = (state_q == StRun) & ~clr_start_i;

    rr_arbiter2 u_arb (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .valid_i  ({r1_valid_i, r0_valid_i}),
        .enable_i (arb_enable),
        .ready_o  (arb_ready),
        .grant_o  (arb_grant),
        .prio_o   (arb_prio)
    );

    // Next-state: arbitrate in RUN, walk every address writing zero in CLEAR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        lg_d    = lg_q;
        unique case (state_q)
            StRun: begin
                if (clr_start_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (arb_grant[0]) begin
                    load_d = 1'b1;
                    addr_d = r0_addr_i;
                    data_d = r0_data_i;
                    lg_d   = 1'b0;
                end else if (arb_grant[1]) begin
                    load_d = 1'b1;
                    addr_d = r1_addr_i;
                    data_d = r1_data_i;
                    lg_d   = 1'b1;
                end
            end
            StClear: begin
                load_d = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                cnt_d  = cnt_q + 1'b1;
                // clr_start is ignored here; the walk always finishes at the last address.
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // FSM, clear counter and registered register-file outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StRun;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            lg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            lg_q    <= lg_d;
        end
    end

    assign r0_ready_o   = arb_ready[0];
    assign r1_ready_o   = arb_ready[1];
    assign rf_load_o    = load_q;
    assign rf_address_o = addr_q;
    assign rf_d_in_o    = data_q;
    assign clr_busy_o   = busy_q;
    assign last_grant_o = lg_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter with a behavioural 8x8 register file behind it. Expected
// register-file writes are queued by the stimulus and checked by an independent monitor.
module tb_rf_write_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr_start = 1'b0;
    logic       clr_busy;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic       r0_ready, r1_ready;
    logic [2:0] r0_addr = '0, r1_addr = '0;
    logic [7:0] r0_data = '0, r1_data = '0;
    logic       rf_load;
    logic [2:0] rf_address;
    logic [7:0] rf_d_in;
    logic       last_grant;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    logic [7:0]  regs [8] = '{default: 8'h00};

    rf_write_arbiter dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .clr_start_i  (clr_start),
        .clr_busy_o   (clr_busy),
        .r0_valid_i   (r0_valid),
        .r0_ready_o   (r0_ready),
        .r0_addr_i    (r0_addr),
        .r0_data_i    (r0_data),
        .r1_valid_i   (r1_valid),
        .r1_ready_o   (r1_ready),
        .r1_addr_i    (r1_addr),
        .r1_data_i    (r1_data),
        .rf_load_o    (rf_load),
        .rf_address_o (rf_address),
        .rf_d_in_o    (rf_d_in),
        .last_grant_o (last_grant)
    );

    always #5 clk = ~clk;

    // FileRegister model: writes at the rising edge while load is high.
    always @(posedge clk) begin
        if (!reset && rf_load) regs[rf_address] <= rf_d_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && rf_load) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h want no write (t=%0t)",
                         rf_address, rf_d_in, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 32'(rf_address), 32'(mon_e[10:8]));
                chk("write_data", 32'(rf_d_in), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        tick();
    endtask

    task automatic preload(input logic [7:0] val);
        for (int a = 0; a < 8; a++) begin
            r0_valid = 1'b1;
            r0_addr  = 3'(a);
            r0_data  = val;
            exp_q.push_back({3'(a), val});
            tick();
        end
        r0_valid = 1'b0;
        wait_drain();
    endtask

    task automatic check_outputs_reset(input string name);
        chk({name, "_load"}, 32'(rf_load), 0);
        chk({name, "_addr"}, 32'(rf_address), 0);
        chk({name, "_din"}, 32'(rf_d_in), 0);
        chk({name, "_busy"}, 32'(clr_busy), 0);
        chk({name, "_lastgrant"}, 32'(last_grant), 0);
    endtask

    initial begin
        int n;
        logic accepted;
        // Power-on reset state.
        #2;
        check_outputs_reset("por");
        @(posedge clk);
        #1 reset = 1'b0;

        // Single r0 write.
        r0_valid = 1'b1; r0_addr = 3'd3; r0_data = 8'hAA;
        exp_q.push_back({3'd3, 8'hAA});
        @(negedge clk);
        chk("t2_r0_ready", 32'(r0_ready), 1);
        chk("t2_r1_ready", 32'(r1_ready), 0);
        tick();
        r0_valid = 1'b0;
        chk("t2_lastgrant", 32'(last_grant), 0);
        tick();
        chk("t2_reg3", 32'(regs[3]), 32'h AA);

        // Single r1 write.
        r1_valid = 1'b1; r1_addr = 3'd5; r1_data = 8'h55;
        exp_q.push_back({3'd5, 8'h55});
        @(negedge clk);
        chk("r1_only_ready", 32'(r1_ready), 1);
        tick();
        r1_valid = 1'b0;
        chk("r1_only_lastgrant", 32'(last_grant), 1);
        tick();

        // Reset mid-activity: a write just registered is discarded.
        r1_valid = 1'b1; r1_addr = 3'd4; r1_data = 8'h44;
        tick();
        reset = 1'b1;
        #1;
        check_outputs_reset("t1");
        r1_valid = 1'b0;
        #9 reset = 1'b0;
        tick();
        chk("t1_reg4_untouched", 32'(regs[4]), 0);

        // Both valid from prio=0: strict alternation.
        r0_valid = 1'b1; r0_addr = 3'd1; r0_data = 8'h11;
        r1_valid = 1'b1; r1_addr = 3'd2; r1_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k % 2 == 0) ? {3'd1, 8'h11} : {3'd2, 8'h22});
            @(negedge clk);
            chk("t3_r0_ready", 32'(r0_ready), 32'(k % 2 == 0));
            chk("t3_r1_ready", 32'(r1_ready), 32'(k % 2 == 1));
            if (k > 0) begin
                chk("t3_load", 32'(rf_load), 1);
                chk("t3_lastgrant", 32'(last_grant), 32'((k - 1) % 2));
            end
            tick();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        chk("t3_load_last", 32'(rf_load), 1);
        chk("t3_lastgrant_last", 32'(last_grant), 1);
        tick();
        @(negedge clk);
        chk("t3_load_idle", 32'(rf_load), 0);
        tick();

        // Clear after preloading every register.
        preload(8'hCC);
        for (int a = 0; a < 8; a++) chk("t4_preload", 32'(regs[a]), 32'h CC);
        clr_start = 1'b1;
        for (int a = 0; a < 8; a++) exp_q.push_back({3'(a), 8'h00});
        @(negedge clk);
        chk("t4_ready_on_start", 32'({r0_ready, r1_ready}), 0);
        tick();
        clr_start = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!clr_busy) break;
            n++;
            chk("t4_ready_busy", 32'({r0_ready, r1_ready}), 0);
        end
        chk("t4_busy_cycles", n, 8);
        wait_drain();
        for (int a = 0; a < 8; a++) chk("t4_reg_zero", 32'(regs[a]), 0);

        // Clear versus r1, plus a redundant clr_start mid-clear.
        clr_start = 1'b1;
        r1_valid = 1'b1; r1_addr = 3'd6; r1_data = 8'h66;
        for (int a = 0; a < 8; a++) exp_q.push_back({3'(a), 8'h00});
        exp_q.push_back({3'd6, 8'h66});
        @(negedge clk);
        chk("t5_r1_blocked", 32'(r1_ready), 0);
        tick();
        clr_start = 1'b0;
        n = 0;
        accepted = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            clr_start = 1'b0;
            if (clr_busy) begin
                n++;
                chk("t5_r1_ready_busy", 32'(r1_ready), 0);
                if (n == 3) clr_start = 1'b1;
            end else begin
                chk("t5_r1_ready_after", 32'(r1_ready), 1);
                accepted = 1'b1;
                break;
            end
        end
        chk("t5_busy_cycles", n, 8);
        chk("t5_accepted", 32'(accepted), 1);
        tick();
        r1_valid = 1'b0;
        wait_drain();
        chk("t5_reg6", 32'(regs[6]), 32'h66);
        chk("t5_lastgrant", 32'(last_grant), 1);

        // Reset aborts a clear at its fourth cycle.
        preload(8'hCC);
        clr_start = 1'b1;
        for (int a = 0; a < 3; a++) exp_q.push_back({3'(a), 8'h00});
        tick();
        clr_start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("t6_load", 32'(rf_load), 0);
        chk("t6_busy", 32'(clr_busy), 0);
        #9 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_write", 32'(rf_load), 0);
        end
        wait_drain();
        for (int a = 0; a < 3; a++) chk("t6_reg_zeroed", 32'(regs[a]), 0);
        for (int a = 4; a < 8; a++) chk("t6_reg_kept", 32'(regs[a]), 32'h CC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
